lut_port_arbiter: RTL and testbench

- Shares one synchronous-read sine LUT read port between N phase-accumulator requesters (carrier, mod, fm by default).
- Lets the modulation datapath run on a single LUT port instead of three.
- Uses round-robin arbitration with a req/ack handshake and a tagged read-return pipeline, so data returns only to the requester that issued the address.
- Sits between the phase accumulators/quadrant logic and the LUT memory.

---
 rtl/lut_port_arbiter_if.sv | 30 +++
 rtl/lut_port_arbiter.sv | 127 ++++++++++++
 tb/tb_lut_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_port_arbiter_if.sv
// Bundle of the requester handshake, read-return and LUT memory signals for
// lut_port_arbiter.
//   req     [N]          per-requester read request, held until ack
//   adr     [N*ADDR_W]   packed requester addresses, slot i at [i*ADDR_W +: ADDR_W]
//   ack     [N]          one-cycle grant pulse per requester
//   rvalid  [N]          one-cycle read-return pulse per requester
//   rdat    [DATA_W]     read data, qualified by rvalid
//   lut_re               LUT read enable
//   lut_adr [ADDR_W]     LUT address
//   lut_dat [DATA_W]     LUT read data, LUT_LAT cycles after lut_re
// slave  : arbiter side.  master : requesters + LUT memory side.
interface lut_port_arbiter_if #(
  parameter int N      = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [N-1:0]        req;
  logic [N*ADDR_W-1:0] adr;
  logic [N-1:0]        ack;
  logic [N-1:0]        rvalid;
  logic [DATA_W-1:0]   rdat;
  logic                lut_re;
  logic [ADDR_W-1:0]   lut_adr;
  logic [DATA_W-1:0]   lut_dat;

  modport slave  (input  req, adr, lut_dat,
                  output ack, rvalid, rdat, lut_re, lut_adr);
  modport master (output req, adr, lut_dat,
                  input  ack, rvalid, rdat, lut_re, lut_adr);
endinterface

// File: rtl/lut_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sine LUT port between N
// phase-accumulator requesters. Each grant pushes a tag into a LUT_LAT+1 deep
// shift register so the returning word is steered only to the requester that
// issued the address, at a fixed LUT_LAT+1 cycles after its ack.
// Ports:
//   sys_clk   clock
//   sys_rst   asynchronous active-high reset
//   bus       lut_port_arbiter_if.slave (req/adr/ack/rvalid/rdat/lut_*)
// Optional (macro LUT_ARB_STATS_EN):
//   stats_clr in  1      synchronous clear of the wait counters
//   wait_cnt  out N*16   per-requester saturating wait-cycle counters
module lut_port_arbiter #(
  parameter int N       = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int LUT_LAT = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  lut_port_arbiter_if.slave  bus
`ifdef LUT_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [N*16-1:0]    wait_cnt
`endif
);

  localparam int IDX_W = $clog2(N);
  localparam int TAG_D = LUT_LAT + 1;

  logic [N-1:0]                 ack_q, ack_d;
  logic [N-1:0]                 rvalid_q, rvalid_d;
  logic [DATA_W-1:0]            rdat_q, rdat_d;
  logic                         lut_re_q, lut_re_d;
  logic [ADDR_W-1:0]            lut_adr_q, lut_adr_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic [TAG_D-1:0]             tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;

  logic [N-1:0]                 eligible;
  logic [N-1:0]                 grant;
  logic                         win_vld;
  logic [IDX_W-1:0]             win_idx;
  logic [IDX_W-1:0]             cand;

  // Search order ptr+1, ptr+2, ... wrapping; the pointer itself comes last.
  always_comb begin
    eligible = bus.req & ~ack_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDX_W'((32'(ptr_q) + off) % N);
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    grant = win_vld ? (N'(1) << win_idx) : '0;
  end

  always_comb begin
    ack_d     = grant;
    lut_re_d  = win_vld;
    lut_adr_d = win_vld ? bus.adr[win_idx*ADDR_W +: ADDR_W] : lut_adr_q;
    ptr_d     = win_vld ? win_idx : ptr_q;
    tag_vld_d = {tag_vld_q[TAG_D-2:0], win_vld};
    tag_idx_d = {tag_idx_q[TAG_D-2:0], win_idx};
    rvalid_d  = '0;
    rdat_d    = rdat_q;
    // The oldest tag lines up with the LUT word for the address it issued.
    if (tag_vld_q[TAG_D-1]) begin
      rvalid_d = N'(1) << tag_idx_q[TAG_D-1];
      rdat_d   = bus.lut_dat;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdat_q    <= '0;
      lut_re_q  <= 1'b0;
      lut_adr_q <= '0;
      ptr_q     <= IDX_W'(N - 1);
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      rdat_q    <= rdat_d;
      lut_re_q  <= lut_re_d;
      lut_adr_q <= lut_adr_d;
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdat    = rdat_q;
  assign bus.lut_re  = lut_re_q;
  assign bus.lut_adr = lut_adr_q;

`ifdef LUT_ARB_STATS_EN
  logic [N-1:0][15:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (stats_clr)
        wait_cnt_d[i] = '0;
      else if (eligible[i] && !grant[i] && (wait_cnt_q[i] != '1))
        wait_cnt_d[i] = wait_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end

  assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Directed bench for lut_port_arbiter: one instance with LUT_LAT=1 and one
// with LUT_LAT=3, each fed by a behavioural registered-read LUT model.
// The wait-counter checks are built only when LUT_ARB_STATS_EN is defined.
module tb_lut_port_arbiter;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 sys_clk = ~sys_clk;

  lut_port_arbiter_if #(.N(3), .ADDR_W(10), .DATA_W(16)) b1 ();
  lut_port_arbiter_if #(.N(3), .ADDR_W(10), .DATA_W(16)) b3 ();

`ifdef LUT_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [47:0] wait_cnt1;
  logic [47:0] wait_cnt3;
`endif

  lut_port_arbiter #(.N(3), .ADDR_W(10), .DATA_W(16), .LUT_LAT(1)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus       (b1)
`ifdef LUT_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .wait_cnt  (wait_cnt1)
`endif
  );

  lut_port_arbiter #(.N(3), .ADDR_W(10), .DATA_W(16), .LUT_LAT(3)) dut3 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bus       (b3)
`ifdef LUT_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .wait_cnt  (wait_cnt3)
`endif
  );

  // LUT contents: distinct word per address.
  function automatic logic [15:0] lut_f(input logic [9:0] a);
    return {a[5:0], a} ^ 16'h5A3C;
  endfunction

  // Latency-1 LUT.
  always @(posedge sys_clk)
    if (b1.lut_re) b1.lut_dat <= lut_f(b1.lut_adr);

  // Latency-3 LUT.
  logic [15:0] l3_s0, l3_s1, l3_s2;
  always @(posedge sys_clk) begin
    if (b3.lut_re) l3_s0 <= lut_f(b3.lut_adr);
    l3_s1 <= l3_s0;
    l3_s2 <= l3_s1;
  end
  assign b3.lut_dat = l3_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    b1.req  = '0;
    b3.req  = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [9:0] a [3];
    int         g;

    b1.req = '0; b1.adr = '0;
    b3.req = '0; b3.adr = '0;

    // Reset values
    do_reset();
    chk("rst_ack",     b1.ack,     3'b000);
    chk("rst_rvalid",  b1.rvalid,  3'b000);
    chk("rst_rdat",    b1.rdat,    16'h0);
    chk("rst_lut_re",  b1.lut_re,  1'b0);
    chk("rst_lut_adr", b1.lut_adr, 10'h0);

    // Single requester 1 held: grant every 2nd cycle, return 2 cycles later
    b1.adr = {10'h000, 10'h155, 10'h000};
    b1.req = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t1_ack_k%0d", k), b1.ack, (k <= 5 && k % 2 == 1) ? 3'b010 : 3'b000);
      chk($sformatf("t1_re_k%0d", k), b1.lut_re, (k <= 5 && k % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("t1_adr_k%0d", k), b1.lut_adr, 10'h155);
      chk($sformatf("t1_rv_k%0d", k), b1.rvalid,
          (k >= 3 && k <= 7 && k % 2 == 1) ? 3'b010 : 3'b000);
      if (k >= 3 && k % 2 == 1)
        chk($sformatf("t1_rdat_k%0d", k), b1.rdat, lut_f(10'h155));
      if (k == 5) b1.req = 3'b000;
    end

    // All three held after reset: 0,1,2,0,1,2
    do_reset();
    b1.adr = {10'h003, 10'h002, 10'h001};
    b1.req = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k <= 6) begin
        chk($sformatf("t2_ack_k%0d", k), b1.ack, 3'b001 << ((k - 1) % 3));
        chk($sformatf("t2_re_k%0d", k), b1.lut_re, 1'b1);
        chk($sformatf("t2_adr_k%0d", k), b1.lut_adr, ((k - 1) % 3) + 1);
      end else begin
        chk($sformatf("t2_ack_k%0d", k), b1.ack, 3'b000);
        chk($sformatf("t2_re_k%0d", k), b1.lut_re, 1'b0);
      end
      if (k >= 3 && k <= 8) begin
        chk($sformatf("t2_rv_k%0d", k), b1.rvalid, 3'b001 << ((k - 3) % 3));
        chk($sformatf("t2_rdat_k%0d", k), b1.rdat, lut_f(10'(((k - 3) % 3) + 1)));
      end else begin
        chk($sformatf("t2_rv_k%0d", k), b1.rvalid, 3'b000);
      end
      if (k == 6) b1.req = 3'b000;
    end

    // Requesters 0 and 2 only: alternate 0,2,0,2, never 1
    do_reset();
    a[0] = 10'h0F0; a[1] = 10'h111; a[2] = 10'h2AA;
    b1.adr = {a[2], a[1], a[0]};
    b1.req = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      step();
      g = (k % 2 == 1) ? 0 : 2;
      chk($sformatf("t3_ack_k%0d", k), b1.ack, 3'b001 << g);
      chk($sformatf("t3_adr_k%0d", k), b1.lut_adr, a[g]);
      if (k >= 3) begin
        g = (k % 2 == 1) ? 0 : 2;
        chk($sformatf("t3_rv_k%0d", k), b1.rvalid, 3'b001 << g);
        chk($sformatf("t3_rdat_k%0d", k), b1.rdat, lut_f(a[g]));
      end else begin
        chk($sformatf("t3_rv_k%0d", k), b1.rvalid, 3'b000);
      end
    end
    b1.req = 3'b000;

    // Asynchronous reset in the middle of traffic
    do_reset();
    b1.adr = {10'h003, 10'h002, 10'h001};
    b1.req = 3'b111;
    repeat (4) step();
    chk("t4_pre_rv", b1.rvalid, 3'b010);
    sys_rst = 1'b1;
    #1;
    chk("t4_async_ack",    b1.ack,    3'b000);
    chk("t4_async_rvalid", b1.rvalid, 3'b000);
    chk("t4_async_lut_re", b1.lut_re, 1'b0);
    chk("t4_async_rdat",   b1.rdat,   16'h0);
    b1.req = 3'b110;
    repeat (2) step();
    sys_rst = 1'b0;
    step();
    chk("t4_k1_ack", b1.ack,    3'b010);
    chk("t4_k1_rv",  b1.rvalid, 3'b000);
    step();
    chk("t4_k2_ack", b1.ack,    3'b100);
    chk("t4_k2_rv",  b1.rvalid, 3'b000);
    step();
    chk("t4_k3_ack",  b1.ack,    3'b010);
    chk("t4_k3_rv",   b1.rvalid, 3'b010);
    chk("t4_k3_rdat", b1.rdat,   lut_f(10'h002));
    b1.req = 3'b000;

    // LUT_LAT=3: burst of four grants, each return 4 cycles after its ack
    do_reset();
    a[0] = 10'h0B5; a[1] = 10'h24A; a[2] = 10'h3C3;
    b3.adr = {a[2], a[1], a[0]};
    b3.req = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k <= 4) begin
        g = (k - 1) % 3;
        chk($sformatf("t5_ack_k%0d", k), b3.ack, 3'b001 << g);
        chk($sformatf("t5_adr_k%0d", k), b3.lut_adr, a[g]);
        chk($sformatf("t5_rv_k%0d", k), b3.rvalid, 3'b000);
      end else if (k <= 8) begin
        g = (k - 5) % 3;
        chk($sformatf("t5_ack_k%0d", k), b3.ack, 3'b000);
        chk($sformatf("t5_rv_k%0d", k), b3.rvalid, 3'b001 << g);
        chk($sformatf("t5_rdat_k%0d", k), b3.rdat, lut_f(a[g]));
      end else begin
        chk($sformatf("t5_rv_k%0d", k), b3.rvalid, 3'b000);
      end
      if (k == 4) b3.req = 3'b000;
    end

`ifdef LUT_ARB_STATS_EN
    // Wait counters: 30 edges with all three held -> 10, 10, 11
    do_reset();
    b1.adr = {10'h003, 10'h002, 10'h001};
    b1.req = 3'b111;
    repeat (30) step();
    chk("t6_wait0", wait_cnt1[15:0],  16'd10);
    chk("t6_wait1", wait_cnt1[31:16], 16'd10);
    chk("t6_wait2", wait_cnt1[47:32], 16'd11);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("t6_clr0", wait_cnt1[15:0],  16'd0);
    chk("t6_clr1", wait_cnt1[31:16], 16'd0);
    chk("t6_clr2", wait_cnt1[47:32], 16'd0);
    b1.req = 3'b000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
